// File: rtl/tile_sched_pkg.sv
// Shared constants and state encoding for the tile scheduler.
// Defaults describe the 16x16 systolic array running a 34x34x16 IFM through 32 3x3 filters.
package tile_sched_pkg;

    localparam int DEF_SYSTOLIC_SIZE = 16;
    localparam int DEF_IFM_SIZE      = 34;
    localparam int DEF_IFM_CHANNEL   = 16;
    localparam int DEF_KERNEL_SIZE   = 3;
    localparam int DEF_NO_FILTER     = 32;

    function automatic int calc_ofm_size(input int ifm_size, input int kernel_size);
        return ifm_size - kernel_size + 1;
    endfunction

    localparam int OFM_SIZE           = calc_ofm_size(DEF_IFM_SIZE, DEF_KERNEL_SIZE);
    localparam int NO_TILING_PER_LINE = DEF_IFM_SIZE / DEF_SYSTOLIC_SIZE;
    localparam int NO_TILING          = OFM_SIZE * NO_TILING_PER_LINE;
    localparam int NO_GROUP           = DEF_NO_FILTER / DEF_SYSTOLIC_SIZE;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_WGT_REQ  = 3'd1;
    localparam state_t S_WGT_WAIT = 3'd2;
    localparam state_t S_IFM_REQ  = 3'd3;
    localparam state_t S_IFM_WAIT = 3'd4;
    localparam state_t S_CMP_WAIT = 3'd5;
    localparam state_t S_DRAIN    = 3'd6;

endpackage

// File: rtl/tile_addr_gen.sv
// Filter-group / tile counters and the base addresses derived from them.
// Counters only move on strobes from the scheduler FSM; addresses are pure functions of the counters.
module tile_addr_gen
    import tile_sched_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
    parameter int IFM_SIZE      = DEF_IFM_SIZE,
    parameter int IFM_CHANNEL   = DEF_IFM_CHANNEL,
    parameter int KERNEL_SIZE   = DEF_KERNEL_SIZE,
    parameter int CF_W          = 2,
    parameter int CT_W          = 7,
    parameter int WGT_W         = 13,
    parameter int IFM_W         = 11,
    parameter int OFM_W         = 15
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc_t,
    input  logic             i_next_g,
    output logic [CF_W-1:0]  o_g,
    output logic [CT_W-1:0]  o_t,
    output logic [WGT_W-1:0] o_wgt_addr,
    output logic [IFM_W-1:0] o_ifm_addr,
    output logic [OFM_W-1:0] o_ofm_addr
);

    localparam int OFM_SZ       = calc_ofm_size(IFM_SIZE, KERNEL_SIZE);
    localparam int NTPL         = IFM_SIZE / SYSTOLIC_SIZE;
    localparam int WGT_STRIDE   = SYSTOLIC_SIZE * IFM_CHANNEL * KERNEL_SIZE * KERNEL_SIZE;
    localparam int OFM_G_STRIDE = SYSTOLIC_SIZE * OFM_SZ * OFM_SZ;

    logic [CF_W-1:0] r_g;
    logic [CT_W-1:0] r_t;
    logic [31:0]     w_row;
    logic [31:0]     w_col;

    // Moving to the next filter group always restarts the tile walk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g <= '0;
            r_t <= '0;
        end else if (i_clr) begin
            r_g <= '0;
            r_t <= '0;
        end else if (i_next_g) begin
            r_g <= r_g + CF_W'(1);
            r_t <= '0;
        end else if (i_inc_t) begin
            r_t <= r_t + CT_W'(1);
        end
    end

    assign w_row = 32'(r_t) / 32'(NTPL);
    assign w_col = 32'(r_t) % 32'(NTPL);

    assign o_g        = r_g;
    assign o_t        = r_t;
    assign o_wgt_addr = WGT_W'(32'(r_g) * 32'(WGT_STRIDE));
    assign o_ifm_addr = IFM_W'(w_row * 32'(IFM_SIZE) + w_col * 32'(SYSTOLIC_SIZE));
    assign o_ofm_addr = OFM_W'(32'(r_g) * 32'(OFM_G_STRIDE) + w_row * 32'(OFM_SZ)
                               + w_col * 32'(SYSTOLIC_SIZE));

endmodule

// File: rtl/tile_scheduler.sv
// Sequencer for the systolic convolution datapath: walks filter groups x output tiles and
// issues load/compute/store requests, overlapping the OFM store of one tile with the next IFM load.
module tile_scheduler
    import tile_sched_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
    parameter int IFM_SIZE      = DEF_IFM_SIZE,
    parameter int IFM_CHANNEL   = DEF_IFM_CHANNEL,
    parameter int KERNEL_SIZE   = DEF_KERNEL_SIZE,
    parameter int NO_FILTER     = DEF_NO_FILTER
)(
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic wgt_load_start,
    output logic ifm_load_start,
    output logic compute_start,
    output logic ofm_store_start,
    input  logic wgt_load_done,
    input  logic ifm_load_done,
    input  logic compute_done,
    input  logic ofm_store_done,
    output logic [$clog2(NO_FILTER*IFM_CHANNEL*KERNEL_SIZE*KERNEL_SIZE)-1:0] wgt_base_addr,
    output logic [$clog2(IFM_SIZE*IFM_SIZE)-1:0] ifm_base_addr,
    output logic [$clog2((IFM_SIZE-KERNEL_SIZE+1)*(IFM_SIZE-KERNEL_SIZE+1)*NO_FILTER)-1:0] ofm_base_addr,
    output logic [$clog2(NO_FILTER/SYSTOLIC_SIZE):0] count_filter,
    output logic [$clog2((IFM_SIZE-KERNEL_SIZE+1)*(IFM_SIZE/SYSTOLIC_SIZE)):0] count_tiling,
    output logic busy,
    output logic done
);

    localparam int OFM_SZ = calc_ofm_size(IFM_SIZE, KERNEL_SIZE);
    localparam int NTILE  = OFM_SZ * (IFM_SIZE / SYSTOLIC_SIZE);
    localparam int NGRP   = NO_FILTER / SYSTOLIC_SIZE;
    localparam int WGT_W  = $clog2(NO_FILTER * IFM_CHANNEL * KERNEL_SIZE * KERNEL_SIZE);
    localparam int IFM_W  = $clog2(IFM_SIZE * IFM_SIZE);
    localparam int OFM_W  = $clog2(OFM_SZ * OFM_SZ * NO_FILTER);
    localparam int CF_W   = $clog2(NGRP) + 1;
    localparam int CT_W   = $clog2(NTILE) + 1;

    state_t           r_state;
    logic             r_wgt_start;
    logic             r_ifm_start;
    logic             r_cmp_start;
    logic             r_st_start;
    logic             r_busy;
    logic             r_done;
    logic             r_ifm_out;
    logic             r_ifm_rdy;
    logic             r_st_pend;
    logic [OFM_W-1:0] r_ofm_addr;

    logic             w_accept;
    logic             w_clr;
    logic             w_inc_t;
    logic             w_next_g;
    logic             w_ifm_done_ok;
    logic             w_ifm_rdy;
    logic             w_st_busy;
    logic             w_cmp_go;
    logic             w_st_issue;
    logic             w_ifm_issue;
    logic             w_last_tile;
    logic             w_last_grp;
    logic [CF_W-1:0]  w_g;
    logic [CT_W-1:0]  w_t;
    logic [WGT_W-1:0] w_wgt_addr;
    logic [IFM_W-1:0] w_ifm_addr;
    logic [OFM_W-1:0] w_ofm_addr;

    tile_addr_gen #(
        .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
        .IFM_SIZE      (IFM_SIZE),
        .IFM_CHANNEL   (IFM_CHANNEL),
        .KERNEL_SIZE   (KERNEL_SIZE),
        .CF_W          (CF_W),
        .CT_W          (CT_W),
        .WGT_W         (WGT_W),
        .IFM_W         (IFM_W),
        .OFM_W         (OFM_W)
    ) u_addr (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_inc_t    (w_inc_t),
        .i_next_g   (w_next_g),
        .o_g        (w_g),
        .o_t        (w_t),
        .o_wgt_addr (w_wgt_addr),
        .o_ifm_addr (w_ifm_addr),
        .o_ofm_addr (w_ofm_addr)
    );

    // Look-ahead views of the flags so a completion pulse is acted on at the edge it arrives.
    assign w_ifm_done_ok = ifm_load_done & r_ifm_out;
    assign w_ifm_rdy     = r_ifm_rdy | w_ifm_done_ok;
    assign w_st_busy     = r_st_pend & ~ofm_store_done;
    assign w_last_tile   = (32'(w_t) == 32'(NTILE - 1));
    assign w_last_grp    = (32'(w_g) == 32'(NGRP - 1));
    assign w_accept      = (r_state == S_IDLE) & start;
    assign w_cmp_go      = (r_state == S_IFM_WAIT) & w_ifm_rdy & ~w_st_busy;
    assign w_st_issue    = (r_state == S_CMP_WAIT) & compute_done;
    assign w_ifm_issue   = ((r_state == S_WGT_WAIT) & wgt_load_done) | w_inc_t;

    always_comb begin
        w_clr    = 1'b0;
        w_inc_t  = 1'b0;
        w_next_g = 1'b0;
        case (r_state)
            S_IDLE:     w_clr    = start;
            S_CMP_WAIT: w_inc_t  = compute_done & ~w_last_tile;
            S_DRAIN:    w_next_g = ~w_st_busy & ~w_last_grp;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wgt_start <= 1'b0;
            r_ifm_start <= 1'b0;
            r_cmp_start <= 1'b0;
            r_st_start  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ofm_addr  <= '0;
        end else begin
            r_wgt_start <= 1'b0;
            r_ifm_start <= 1'b0;
            r_cmp_start <= 1'b0;
            r_st_start  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_wgt_start <= 1'b1;
                        r_state     <= S_WGT_REQ;
                    end
                end
                S_WGT_REQ: r_state <= S_WGT_WAIT;
                S_WGT_WAIT: begin
                    if (wgt_load_done) begin
                        r_ifm_start <= 1'b1;
                        r_state     <= S_IFM_REQ;
                    end
                end
                S_IFM_REQ: r_state <= S_IFM_WAIT;
                S_IFM_WAIT: begin
                    if (w_cmp_go) begin
                        r_cmp_start <= 1'b1;
                        r_state     <= S_CMP_WAIT;
                    end
                end
                // The next tile's IFM load goes out alongside this tile's store.
                S_CMP_WAIT: begin
                    if (compute_done) begin
                        r_st_start <= 1'b1;
                        r_ofm_addr <= w_ofm_addr;
                        if (!w_last_tile) begin
                            r_ifm_start <= 1'b1;
                            r_state     <= S_IFM_WAIT;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!w_st_busy) begin
                        if (!w_last_grp) begin
                            r_wgt_start <= 1'b1;
                            r_state     <= S_WGT_REQ;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outstanding-request bookkeeping; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifm_out <= 1'b0;
            r_ifm_rdy <= 1'b0;
            r_st_pend <= 1'b0;
        end else if (w_accept) begin
            r_ifm_out <= 1'b0;
            r_ifm_rdy <= 1'b0;
            r_st_pend <= 1'b0;
        end else begin
            if (w_ifm_done_ok) begin
                r_ifm_out <= 1'b0;
                r_ifm_rdy <= 1'b1;
            end
            if (w_cmp_go) begin
                r_ifm_rdy <= 1'b0;
            end
            if (w_ifm_issue) begin
                r_ifm_out <= 1'b1;
                r_ifm_rdy <= 1'b0;
            end
            if (ofm_store_done) begin
                r_st_pend <= 1'b0;
            end
            if (w_st_issue) begin
                r_st_pend <= 1'b1;
            end
        end
    end

    assign wgt_load_start  = r_wgt_start;
    assign ifm_load_start  = r_ifm_start;
    assign compute_start   = r_cmp_start;
    assign ofm_store_start = r_st_start;
    assign wgt_base_addr   = w_wgt_addr;
    assign ifm_base_addr   = w_ifm_addr;
    assign ofm_base_addr   = r_ofm_addr;
    assign count_filter    = w_g;
    assign count_tiling    = w_t;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed testbench for tile_scheduler: hand-driven handshakes plus a full run
// against latency-modelled responders for the load, compute and store units.
module tb_tile_scheduler;

    localparam int WGT_LAT = 3;
    localparam int IFM_LAT = 3;
    localparam int CMP_LAT = 5;
    localparam int ST_LAT  = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        wgt_load_start;
    logic        ifm_load_start;
    logic        compute_start;
    logic        ofm_store_start;
    logic        wgt_load_done;
    logic        ifm_load_done;
    logic        compute_done;
    logic        ofm_store_done;
    logic [12:0] wgt_base_addr;
    logic [10:0] ifm_base_addr;
    logic [14:0] ofm_base_addr;
    logic [1:0]  count_filter;
    logic [6:0]  count_tiling;
    logic        busy;
    logic        done;

    logic wgtDoneMan, ifmDoneMan, cmpDoneMan, stDoneMan;
    logic wgtDoneAuto, ifmDoneAuto, cmpDoneAuto, stDoneAuto;
    logic autoResp;
    int   wgtCnt, ifmCnt, cmpCnt, stCnt;

    int   checks;
    int   failures;
    int   nWgt, nIfm, nCmp, nSt, nStDone, nDoneRise, stDoneAtDone;
    logic prevDone;
    int   capWgt, capIfm, capOfm;
    int   snapWgt, snapCmp, snapSt, snapStDone, snapDoneRise;
    bit   found;

    tile_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .wgt_load_start  (wgt_load_start),
        .ifm_load_start  (ifm_load_start),
        .compute_start   (compute_start),
        .ofm_store_start (ofm_store_start),
        .wgt_load_done   (wgt_load_done),
        .ifm_load_done   (ifm_load_done),
        .compute_done    (compute_done),
        .ofm_store_done  (ofm_store_done),
        .wgt_base_addr   (wgt_base_addr),
        .ifm_base_addr   (ifm_base_addr),
        .ofm_base_addr   (ofm_base_addr),
        .count_filter    (count_filter),
        .count_tiling    (count_tiling),
        .busy            (busy),
        .done            (done)
    );

    assign wgt_load_done  = wgtDoneMan | wgtDoneAuto;
    assign ifm_load_done  = ifmDoneMan | ifmDoneAuto;
    assign compute_done   = cmpDoneMan | cmpDoneAuto;
    assign ofm_store_done = stDoneMan  | stDoneAuto;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latency-modelled responders: each answers its request with a single done pulse.
    always @(posedge clk) begin
        if (rst || !autoResp) begin
            wgtCnt <= 0; ifmCnt <= 0; cmpCnt <= 0; stCnt <= 0;
            wgtDoneAuto <= 1'b0; ifmDoneAuto <= 1'b0; cmpDoneAuto <= 1'b0; stDoneAuto <= 1'b0;
        end else begin
            wgtDoneAuto <= (wgtCnt == 1);
            ifmDoneAuto <= (ifmCnt == 1);
            cmpDoneAuto <= (cmpCnt == 1);
            stDoneAuto  <= (stCnt == 1);
            if (wgt_load_start) wgtCnt <= WGT_LAT; else if (wgtCnt > 0) wgtCnt <= wgtCnt - 1;
            if (ifm_load_start) ifmCnt <= IFM_LAT; else if (ifmCnt > 0) ifmCnt <= ifmCnt - 1;
            if (compute_start)  cmpCnt <= CMP_LAT; else if (cmpCnt > 0) cmpCnt <= cmpCnt - 1;
            if (ofm_store_start) stCnt <= ST_LAT;  else if (stCnt > 0)  stCnt <= stCnt - 1;
        end
    end

    // Pulse counters and address captures read by the scenario tasks.
    always @(posedge clk) begin
        if (wgt_load_start)  nWgt <= nWgt + 1;
        if (ifm_load_start)  nIfm <= nIfm + 1;
        if (compute_start)   nCmp <= nCmp + 1;
        if (ofm_store_start) nSt  <= nSt + 1;
        if (ofm_store_done)  nStDone <= nStDone + 1;
        prevDone <= done;
        if (done && !prevDone) begin
            nDoneRise    <= nDoneRise + 1;
            stDoneAtDone <= nStDone;
        end
        if (wgt_load_start && count_filter == 2'd1) capWgt <= int'(wgt_base_addr);
        if (ifm_load_start && count_filter == 2'd1 && count_tiling == 7'd3) capIfm <= int'(ifm_base_addr);
        if (ofm_store_start && count_filter == 2'd1 && count_tiling == 7'd4) capOfm <= int'(ofm_base_addr);
    end

    task automatic doReset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0d exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%0d exp=0", done); end
        checks++; if ({wgt_load_start, ifm_load_start, compute_start, ofm_store_start} !== 4'b0000) begin failures++; $display("[TB] FAIL reset_pulses got=%b exp=0000", {wgt_load_start, ifm_load_start, compute_start, ofm_store_start}); end
        checks++; if (wgt_base_addr !== 13'd0) begin failures++; $display("[TB] FAIL reset_wgt_addr got=%0d exp=0", wgt_base_addr); end
        checks++; if (ifm_base_addr !== 11'd0) begin failures++; $display("[TB] FAIL reset_ifm_addr got=%0d exp=0", ifm_base_addr); end
        checks++; if (ofm_base_addr !== 15'd0) begin failures++; $display("[TB] FAIL reset_ofm_addr got=%0d exp=0", ofm_base_addr); end
        checks++; if (count_filter !== 2'd0) begin failures++; $display("[TB] FAIL reset_count_filter got=%0d exp=0", count_filter); end
        checks++; if (count_tiling !== 7'd0) begin failures++; $display("[TB] FAIL reset_count_tiling got=%0d exp=0", count_tiling); end
        rst = 1'b0;
    endtask

    task automatic test_handshake();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL start_busy got=%0d exp=1", busy); end
        checks++; if (wgt_load_start !== 1'b1) begin failures++; $display("[TB] FAIL start_wgt_pulse got=%0d exp=1", wgt_load_start); end
        @(negedge clk);
        checks++; if (wgt_load_start !== 1'b0) begin failures++; $display("[TB] FAIL wgt_pulse_width got=%0d exp=0", wgt_load_start); end
        cmpDoneMan = 1'b1;
        @(negedge clk); cmpDoneMan = 1'b0;
        checks++; if ({ifm_load_start, compute_start, ofm_store_start} !== 3'b000) begin failures++; $display("[TB] FAIL stray_cmp_done got=%b exp=000", {ifm_load_start, compute_start, ofm_store_start}); end
        wgtDoneMan = 1'b1;
        @(negedge clk); wgtDoneMan = 1'b0;
        checks++; if (ifm_load_start !== 1'b1) begin failures++; $display("[TB] FAIL wgt_done_to_ifm got=%0d exp=1", ifm_load_start); end
        checks++; if (ifm_base_addr !== 11'd0) begin failures++; $display("[TB] FAIL ifm_addr_t0 got=%0d exp=0", ifm_base_addr); end
        @(negedge clk);
        checks++; if (ifm_load_start !== 1'b0) begin failures++; $display("[TB] FAIL ifm_pulse_width got=%0d exp=0", ifm_load_start); end
        ifmDoneMan = 1'b1;
        @(negedge clk); ifmDoneMan = 1'b0;
        checks++; if (compute_start !== 1'b1) begin failures++; $display("[TB] FAIL ifm_done_to_cmp got=%0d exp=1", compute_start); end
        @(negedge clk);
        cmpDoneMan = 1'b1;
        @(negedge clk); cmpDoneMan = 1'b0;
        checks++; if ({ofm_store_start, ifm_load_start} !== 2'b11) begin failures++; $display("[TB] FAIL overlap_pulses got=%b exp=11", {ofm_store_start, ifm_load_start}); end
        checks++; if (count_tiling !== 7'd1) begin failures++; $display("[TB] FAIL tile_inc got=%0d exp=1", count_tiling); end
        checks++; if (ifm_base_addr !== 11'd16) begin failures++; $display("[TB] FAIL ifm_addr_t1 got=%0d exp=16", ifm_base_addr); end
        checks++; if (ofm_base_addr !== 15'd0) begin failures++; $display("[TB] FAIL ofm_addr_t0 got=%0d exp=0", ofm_base_addr); end
        // IFM arrives early but the store is held for about 20 cycles.
        snapCmp = nCmp;
        @(negedge clk); ifmDoneMan = 1'b1;
        @(negedge clk); ifmDoneMan = 1'b0;
        repeat (18) @(negedge clk);
        checks++; if (nCmp !== snapCmp) begin failures++; $display("[TB] FAIL cmp_withheld got=%0d exp=%0d", nCmp, snapCmp); end
        stDoneMan = 1'b1;
        @(negedge clk); stDoneMan = 1'b0;
        checks++; if (compute_start !== 1'b1) begin failures++; $display("[TB] FAIL st_done_to_cmp got=%0d exp=1", compute_start); end
        @(negedge clk);
        cmpDoneMan = 1'b1;
        @(negedge clk); cmpDoneMan = 1'b0;
        checks++; if (count_tiling !== 7'd2) begin failures++; $display("[TB] FAIL tile_inc2 got=%0d exp=2", count_tiling); end
        checks++; if (ifm_base_addr !== 11'd34) begin failures++; $display("[TB] FAIL ifm_addr_t2 got=%0d exp=34", ifm_base_addr); end
        checks++; if (ofm_base_addr !== 15'd16) begin failures++; $display("[TB] FAIL ofm_addr_t1 got=%0d exp=16", ofm_base_addr); end
        @(negedge clk);
        @(negedge clk); ifmDoneMan = 1'b1; stDoneMan = 1'b1;
        @(negedge clk); ifmDoneMan = 1'b0; stDoneMan = 1'b0;
        checks++; if (compute_start !== 1'b1) begin failures++; $display("[TB] FAIL simultaneous_done got=%0d exp=1", compute_start); end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (count_tiling !== 7'd2 || count_filter !== 2'd0) begin failures++; $display("[TB] FAIL start_while_busy got=g%0d/t%0d exp=g0/t2", count_filter, count_tiling); end
        checks++; if (wgt_load_start !== 1'b0) begin failures++; $display("[TB] FAIL start_while_busy_wgt got=%0d exp=0", wgt_load_start); end
    endtask

    task automatic test_full_run();
        doReset();
        autoResp = 1'b1;
        snapWgt = nWgt; snapCmp = nCmp; snapSt = nSt; snapStDone = nStDone; snapDoneRise = nDoneRise;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin failures++; $display("[TB] FAIL full_run_timeout got=done0 exp=done1"); end
        repeat (10) @(negedge clk);
        checks++; if (nWgt - snapWgt !== 2) begin failures++; $display("[TB] FAIL wgt_pulses got=%0d exp=2", nWgt - snapWgt); end
        checks++; if (nCmp - snapCmp !== 128) begin failures++; $display("[TB] FAIL cmp_pulses got=%0d exp=128", nCmp - snapCmp); end
        checks++; if (nSt - snapSt !== 128) begin failures++; $display("[TB] FAIL store_pulses got=%0d exp=128", nSt - snapSt); end
        checks++; if (nDoneRise - snapDoneRise !== 1) begin failures++; $display("[TB] FAIL done_rises got=%0d exp=1", nDoneRise - snapDoneRise); end
        checks++; if (stDoneAtDone - snapStDone !== 128) begin failures++; $display("[TB] FAIL done_after_last_store got=%0d exp=128", stDoneAtDone - snapStDone); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_after_done got=%0d exp=0", busy); end
        checks++; if (count_filter !== 2'd1 || count_tiling !== 7'd63) begin failures++; $display("[TB] FAIL final_counters got=g%0d/t%0d exp=g1/t63", count_filter, count_tiling); end
        checks++; if (capWgt !== 2304) begin failures++; $display("[TB] FAIL wgt_addr_g1 got=%0d exp=2304", capWgt); end
        checks++; if (capIfm !== 50) begin failures++; $display("[TB] FAIL ifm_addr_t3 got=%0d exp=50", capIfm); end
        checks++; if (capOfm !== 16432) begin failures++; $display("[TB] FAIL ofm_addr_g1_t3 got=%0d exp=16432", capOfm); end
    endtask

    task automatic test_restart();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL restart_done_clear got=%0d exp=0", done); end
        checks++; if (busy !== 1'b1 || wgt_load_start !== 1'b1) begin failures++; $display("[TB] FAIL restart_busy_wgt got=%b exp=11", {busy, wgt_load_start}); end
        checks++; if (count_filter !== 2'd0 || count_tiling !== 7'd0) begin failures++; $display("[TB] FAIL restart_counters got=g%0d/t%0d exp=g0/t0", count_filter, count_tiling); end
    endtask

    task automatic test_reset_midrun();
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (compute_start === 1'b1 && count_tiling == 7'd10) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin failures++; $display("[TB] FAIL reach_t10_timeout got=none exp=compute_start_t10"); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if ({busy, done, wgt_load_start, ifm_load_start, compute_start, ofm_store_start} !== 6'd0) begin failures++; $display("[TB] FAIL async_reset_flags got=%b exp=000000", {busy, done, wgt_load_start, ifm_load_start, compute_start, ofm_store_start}); end
        checks++; if (count_tiling !== 7'd0 || count_filter !== 2'd0) begin failures++; $display("[TB] FAIL async_reset_counters got=g%0d/t%0d exp=g0/t0", count_filter, count_tiling); end
        checks++; if (ifm_base_addr !== 11'd0 || ofm_base_addr !== 15'd0 || wgt_base_addr !== 13'd0) begin failures++; $display("[TB] FAIL async_reset_addrs got=%0d/%0d/%0d exp=0/0/0", wgt_base_addr, ifm_base_addr, ofm_base_addr); end
        autoResp = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (wgt_load_start !== 1'b1 || busy !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_start got=%b exp=11", {wgt_load_start, busy}); end
        checks++; if (count_tiling !== 7'd0 || count_filter !== 2'd0) begin failures++; $display("[TB] FAIL post_reset_counters got=g%0d/t%0d exp=g0/t0", count_filter, count_tiling); end
    endtask

    initial begin
        checks = 0; failures = 0;
        nWgt = 0; nIfm = 0; nCmp = 0; nSt = 0; nStDone = 0; nDoneRise = 0; stDoneAtDone = 0;
        capWgt = 0; capIfm = 0; capOfm = 0; prevDone = 1'b0;
        rst = 1'b1; start = 1'b0; autoResp = 1'b0;
        wgtDoneMan = 1'b0; ifmDoneMan = 1'b0; cmpDoneMan = 1'b0; stDoneMan = 1'b0;
        test_reset();
        test_handshake();
        test_full_run();
        test_restart();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_scheduler.md
# tile_scheduler

Top-level sequencer for the 16x16 systolic convolution datapath. Walks the filter-group × output-tile loop nest and issues start pulses, with base addresses, to the weight loader, IFM loader, systolic compute engine and OFM writer. Overlaps the OFM store of tile t with the IFM load of tile t+1. Sits inside TOP in place of the flat main control and exposes `count_filter` / `count_tiling` for bench monitoring.

## Interface
- SYSTOLIC_SIZE, 16, PE array edge and filters per group
- IFM_SIZE, 34, input feature map height and width
- IFM_CHANNEL, 16, input channels
- KERNEL_SIZE, 3, kernel edge
- NO_FILTER, 32, output filters; must be a multiple of SYSTOLIC_SIZE
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; accepted only in IDLE
- wgt_load_start / ifm_load_start / compute_start / ofm_store_start  out  1 each  one-cycle request pulses
- wgt_load_done / ifm_load_done / compute_done / ofm_store_done  in  1 each  one-cycle completion pulses
- wgt_base_addr  out  $clog2(NO_FILTER*IFM_CHANNEL*KERNEL_SIZE²)  = g·SYSTOLIC_SIZE·IFM_CHANNEL·KERNEL_SIZE²
- ifm_base_addr  out  $clog2(IFM_SIZE²)  = row·IFM_SIZE + col·SYSTOLIC_SIZE
- ofm_base_addr  out  $clog2(OFM_SIZE²·NO_FILTER)  = g·SYSTOLIC_SIZE·OFM_SIZE² + row·OFM_SIZE + col·SYSTOLIC_SIZE; latched at store issue
- count_filter  out  $clog2(NO_FILTER/SYSTOLIC_SIZE)+1  current filter group g
- count_tiling  out  $clog2(NO_TILING)+1  current tile t; row = t / NO_TILING_PER_LINE, col = t % NO_TILING_PER_LINE
- busy  out  1  high from start acceptance until done
- done  out  1  level; set on completion, cleared when the next start is accepted

## Operation
- Derived values: OFM_SIZE = IFM_SIZE−KERNEL_SIZE+1 = 32; NO_TILING_PER_LINE = IFM_SIZE/SYSTOLIC_SIZE = 2; NO_TILING = 64; NO_GROUP = 2.
- State IDLE: on `start`, clear g and t, set `busy`, clear `done`, go to WGT_REQ.
- WGT_REQ: pulse `wgt_load_start`, go to WGT_WAIT.
- WGT_WAIT: on `wgt_load_done`, go to IFM_REQ.
- IFM_REQ: pulse `ifm_load_start` using the addresses for tile t, go to IFM_WAIT.
- IFM_WAIT: hold until the IFM load is done (flag set by `ifm_load_done`) and no store is pending. Then pulse `compute_start` and go to CMP_WAIT.
- CMP_WAIT: on `compute_done`, pulse `ofm_store_start`, latch `ofm_base_addr`, set `st_pend`.
  - If t < NO_TILING−1: t++ and pulse `ifm_load_start` in the same cycle. This is the overlap. Go to IFM_WAIT.
  - Else go to DRAIN.
- DRAIN: wait for `st_pend` = 0.
  - If g < NO_GROUP−1: g++, t=0, go to WGT_REQ.
  - Else set `done`, clear `busy`, go to IDLE.
- `st_pend` is cleared by `ofm_store_done`. Set has priority over clear in the same cycle (cannot occur legally).
- `ifm_load_done` and `ofm_store_done` in the same cycle are both captured.
- Unexpected completion pulses (no matching outstanding request) are ignored.
- `start` while busy is ignored.

## Timing
- Reset values: all pulses 0, all addresses 0, counters 0, `busy` 0, `done` 0, state IDLE, flags cleared.
- `rst` mid-run aborts immediately to IDLE. In-flight datapath operations are not tracked.
- `start` at edge N: `busy` high after N; `wgt_load_start` high for exactly cycle N+1.
- Any completion pulse at edge N produces its follow-on request pulse during cycle N+1 (one-cycle registered latency).
- Addresses are valid in the same cycle as their start pulse and held until the next request of that type.
- Each request pulse is exactly one cycle wide. No request is reissued before its done.

## Structure
- Package `tile_sched_pkg`:
  - localparams OFM_SIZE, NO_TILING_PER_LINE, NO_TILING, NO_GROUP
  - state enum {IDLE, WGT_REQ, WGT_WAIT, IFM_REQ, IFM_WAIT, CMP_WAIT, DRAIN}
- Sub-module `tile_addr_gen`: holds the g/t counters and row/col decomposition, and produces the three base addresses combinationally from them. The FSM owns the increment and clear strobes.

## Test plan
- Full run, default parameters, responder models with 3-cycle load, 5-cycle compute and 4-cycle store latency → exactly 2 `wgt_load_start`, 128 `compute_start` and 128 `ofm_store_start` pulses. `done` rises once, after the final `ofm_store_done`.
- Address sweep → tile t=3, g=1 gives `ifm_base_addr`=50 (row 1, col 1) and `ofm_base_addr`=16384+32+16=16432; `wgt_base_addr`=2304 for g=1.
- Overlap: hold `ofm_store_done` for 20 cycles → the next `ifm_load_start` issues one cycle after `compute_done`, but `compute_start` is withheld until the cycle after `ofm_store_done`.
- Simultaneous `ifm_load_done` and `ofm_store_done` on the same edge → `compute_start` on the next cycle. Stray `compute_done` in WGT_WAIT is ignored.
- Assert `rst` while in CMP_WAIT at t=10 → all outputs 0 and state IDLE asynchronously. A subsequent `start` restarts at g=0, t=0.
- `start` pulsed while busy → no effect on counters. After `done`, a new `start` clears `done` the next cycle.
